forward_hazard_unit: RTL

//  Parametrised successor to the pipeline forwarding unit. Each cycle it chooses
//  the forwarding source for both f3 (EX) operands, detects load-use hazards

---
 rtl/forward_hazard_unit_pkg.sv | 18 +
 rtl/forward_hazard_unit_if.sv | 50 +++++
 rtl/forward_hazard_unit_fw_select.sv | 35 +++
 rtl/forward_hazard_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline definitions: forwarding-select encoding and the load-use
// stall FSM state type.
package pipe_pkg;

    // Operand source select driven to the EX-stage operand muxes.
    typedef logic [1:0] fw_sel_t;

    localparam fw_sel_t FW_NONE = 2'b00;  // value read from the register file
    localparam fw_sel_t FW_F5   = 2'b01;  // value from the f5 (writeback) stage
    localparam fw_sel_t FW_F4   = 2'b10;  // value from the f4 (memory) stage

    // Load-use stall FSM: IDLE watches for hazards, HOLD extends a stall.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hz_state_e;

endpackage : pipe_pkg

// File: rtl/forward_hazard_unit_if.sv
// Bundle of pipeline-stage signals seen by the forwarding/hazard unit.
// The pipeline datapath takes the master side, the unit takes the slave side.
interface forward_hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);

    // Writers further down the pipe
    logic             reg_f4;
    logic             reg_f5;
    logic [REG_W-1:0] escrita_f4;
    logic [REG_W-1:0] escrita_f5;

    // EX-stage (f3) instruction
    logic [REG_W-1:0] RS_f3;
    logic [REG_W-1:0] RT_f3;
    logic             mem_read_f3;
    logic [REG_W-1:0] escrita_f3;

    // Decode-stage (f2) instruction
    logic [REG_W-1:0] RS_f2;
    logic [REG_W-1:0] RT_f2;
    logic             uses_rt_f2;

    // Control-flow kill of f1/f2
    logic             flush;

    // Results back to the datapath
    logic [1:0]       fw_A;
    logic [1:0]       fw_B;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] fwd_count;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output reg_f4, reg_f5, escrita_f4, escrita_f5,
        output RS_f3, RT_f3, mem_read_f3, escrita_f3,
        output RS_f2, RT_f2, uses_rt_f2, flush,
        input  fw_A, fw_B, stall, bubble, fwd_count, stall_count
    );

    modport slave (
        input  reg_f4, reg_f5, escrita_f4, escrita_f5,
        input  RS_f3, RT_f3, mem_read_f3, escrita_f3,
        input  RS_f2, RT_f2, uses_rt_f2, flush,
        output fw_A, fw_B, stall, bubble, fwd_count, stall_count
    );

endinterface : forward_hazard_unit_if

// File: rtl/forward_hazard_unit_fw_select.sv
// Per-operand forwarding comparator. Picks the youngest in-flight producer
// of one source register: f4 beats f5, so FW_F4|FW_F5 can never appear.
module fw_select
    import pipe_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter bit ZERO_FWD = 1'b0
) (
    input  logic [REG_W-1:0] src,
    input  logic             reg_f4,
    input  logic [REG_W-1:0] escrita_f4,
    input  logic             reg_f5,
    input  logic [REG_W-1:0] escrita_f5,
    output fw_sel_t          sel
);

    logic hit_f4;
    logic hit_f5;

    // Match each writer against the source, then apply f4-over-f5 priority.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path
        // (default first, then overrides), otherwise synthesis infers a latch.
        sel    = FW_NONE;
        // Register 0 is hard-wired zero unless the core treats it as a real register.
        hit_f4 = reg_f4 && (escrita_f4 == src) && (ZERO_FWD || (escrita_f4 != '0));
        hit_f5 = reg_f5 && (escrita_f5 == src) && (ZERO_FWD || (escrita_f5 != '0));
        if (hit_f4) begin
            sel = FW_F4;
        end else if (hit_f5) begin
            sel = FW_F5;
        end
    end

endmodule : fw_select

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit. Selects the EX operand sources,
// stalls f1/f2 for LOAD_LAT cycles behind a load whose result is needed by
// the next instruction, and keeps saturating forward/stall event counters.
module forward_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter bit ZERO_FWD = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    forward_hazard_unit_if.slave bus
);

    // Hold-counter width fits LOAD_LAT-1 remaining cycles.
    localparam int            CW        = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(LOAD_LAT - 1);

    localparam logic [CNT_W-1:0] EVT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] EVT_MAX = {CNT_W{1'b1}};

    fw_sel_t          sel_a;
    fw_sel_t          sel_b;
    fw_sel_t          fw_a;
    fw_sel_t          fw_b;
    logic             hazard;
    logic             stall_c;
    logic             any_fwd;

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic [CNT_W-1:0] fwd_count_q;
    logic [CNT_W-1:0] fwd_count_d;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    // Operand A (RS) source select.
    fw_select #(
        .REG_W    (REG_W),
        .ZERO_FWD (ZERO_FWD)
    ) u_fw_a (
        .src        (bus.RS_f3),
        .reg_f4     (bus.reg_f4),
        .escrita_f4 (bus.escrita_f4),
        .reg_f5     (bus.reg_f5),
        .escrita_f5 (bus.escrita_f5),
        .sel        (sel_a)
    );

    // Operand B (RT) source select.
    fw_select #(
        .REG_W    (REG_W),
        .ZERO_FWD (ZERO_FWD)
    ) u_fw_b (
        .src        (bus.RT_f3),
        .reg_f4     (bus.reg_f4),
        .escrita_f4 (bus.escrita_f4),
        .reg_f5     (bus.reg_f5),
        .escrita_f5 (bus.escrita_f5),
        .sel        (sel_b)
    );

    // Forward selects are forced to the register file while reset is held.
    always_comb begin
        fw_a    = reset ? FW_NONE : sel_a;
        fw_b    = reset ? FW_NONE : sel_b;
        any_fwd = (fw_a != FW_NONE) || (fw_b != FW_NONE);
    end

    // Load in f3 feeding f2; a load into register 0 produces nothing to wait for.
    always_comb begin
        hazard = bus.mem_read_f3
              && (bus.escrita_f3 != '0)
              && ((bus.escrita_f3 == bus.RS_f2)
                  || (bus.uses_rt_f2 && (bus.escrita_f3 == bus.RT_f2)));
    end

    // Stall FSM: the first stall cycle is raised from IDLE, the remaining
    // LOAD_LAT-1 cycles are counted down in HOLD. A flush kills the stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (hazard && !bus.flush) begin
                    stall_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_INIT;
                    end
                end
            end
            HOLD: begin
                if (bus.flush) begin
                    // Killed instruction in f2 no longer needs the load result.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (reset) begin
            stall_c = 1'b0;
        end
    end

    // Saturating event counters: they stick at all-ones instead of wrapping.
    always_comb begin
        fwd_count_d   = fwd_count_q;
        stall_count_d = stall_count_q;
        if (any_fwd && (fwd_count_q != EVT_MAX)) begin
            fwd_count_d = fwd_count_q + EVT_ONE;
        end
        if (stall_c && (stall_count_q != EVT_MAX)) begin
            stall_count_d = stall_count_q + EVT_ONE;
        end
    end

    // State, hold counter and event counters; synchronous reset clears all.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples
        // the pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            // NOTE: only control state is reset; there is no storage array here
            // that would need (or benefit from) clearing.
            state_q       <= IDLE;
            cnt_q         <= '0;
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fwd_count_q   <= fwd_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Drive results back onto the bus.
    always_comb begin
        bus.fw_A        = fw_a;
        bus.fw_B        = fw_b;
        bus.stall       = stall_c;
        bus.bubble      = stall_c;
        bus.fwd_count   = fwd_count_q;
        bus.stall_count = stall_count_q;
    end

endmodule : forward_hazard_unit
